bnn_popcount_neuron: RTL and testbench
======================================

// Module: bnn_popcount_neuron
// PURPOSE
//  Downstream stage of the binary XNOR layer: consumes BEAT_W-bit XNOR match vectors, one beat per handshake.
//  Accumulates the popcount over BEATS beats (fan-in BEAT_W*BEATS), compares it against a programmable threshold,
//  and emits one binary activation per vector plus the raw count.
//  Sits between the XNOR array and the output/next-layer logic that drives uo_out.
// PARAMETERS
//  BEAT_W  8  bits per input beat (XNOR match bits)
//  BEATS   4  beats per neuron vector; legal range >= 1
//  CNT_W   $clog2(BEAT_W*BEATS+1)  count/threshold width (6 at defaults); derived, do not override
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       reset; asynchronous, active-high
//  in_valid    in   1       upstream beat valid
//  in_ready    out  1       this block accepts a beat; transfer = in_valid & in_ready
//  in_bits     in   BEAT_W  XNOR match bits; 1 = match
//  thresh_wr   in   1       load thresh_in into the threshold register this edge
//  thresh_in   in   CNT_W   new threshold value
//  out_valid   out  1       result valid; held until accepted
//  out_ready   in   1       downstream accepts; transfer = out_valid & out_ready
//  out_act     out  1       activation: 1 iff count >= threshold
//  out_count   out  CNT_W   popcount of the full vector
//  busy        out  1       high in ACCUM or EMIT
// BEHAVIOUR
//  Reset (async assert, sync use after deassert): state=IDLE, acc=0, beat_cnt=0, out_valid=0, out_act=0,
//   out_count=0, threshold=(BEAT_W*BEATS)/2 (16 at defaults), in_ready=1, busy=0. Mid-vector reset discards partial sums.
//  FSM IDLE -> ACCUM -> EMIT -> IDLE:
//   IDLE : in_ready=1. On transfer: acc=popcount(in_bits), beat_cnt=1; -> ACCUM (-> EMIT directly if BEATS==1).
//   ACCUM: in_ready=1; gaps in in_valid allowed, state/acc held. On transfer acc+=popcount(in_bits), beat_cnt++;
//          the transfer that completes beat BEATS -> EMIT.
//   EMIT : in_ready=0 (see CONFIGURATION); out_valid=1; out_act/out_count stable. On out_ready -> IDLE, out_valid=0.
//  out_count/out_act are registered on the edge that accepts the final beat; out_valid is high the next cycle
//   (latency 1 cycle from final-beat edge). Compare uses the threshold register value before that edge.
//  Arithmetic: acc is CNT_W wide, unsigned; max BEAT_W*BEATS never overflows. Compare is unsigned >=.
//  thresh_wr: accepted in any state; takes effect at the edge. A write on the final-beat edge does NOT affect the
//   result being produced (old value used). Writes during EMIT do not alter held out_act.
//  in_valid while in_ready=0 is ignored (no capture, no state change).
// CONFIGURATION
//  BNN_PASSTHRU_EN defined: in EMIT, in_ready = out_ready; a beat accepted in the same cycle as the output handshake
//   starts the next vector (acc=popcount(in_bits), beat_cnt=1, -> ACCUM, or -> EMIT if BEATS==1), no bubble.
//  Undefined: in EMIT in_ready=0; one idle cycle between output handshake and next first beat. Results identical.
// STRUCTURE
//  Package bnn_pkg: state typedef enum {IDLE, ACCUM, EMIT}; function clog2-based count width; popcount function.
//  Sub-module bnn_popcount8: combinational BEAT_W-input popcount feeding the accumulator adder.
//  Top holds FSM, beat counter, accumulator, threshold register, output registers.
// TESTING
//  1 Reset: assert rst after 2 of 4 beats -> out_valid=0, in_ready=1, busy=0; next vector FF x4 gives out_count=32.
//  2 4 beats 8'hFF, default thresh 16 -> out_valid 1 cycle after 4th beat, out_count=32, out_act=1.
//  3 Beats FF,0F,00,00 -> out_count=12, out_act=0; write thresh=12, repeat -> out_act=1 (>= boundary); thresh=13 -> 0.
//  4 Backpressure: out_ready=0 for 10 cycles with in_valid=1 -> out_valid/out_count/out_act stable, in_ready=0, no capture.
//  5 thresh_wr(0) on the final-beat edge with count 12, old thresh 16 -> out_act=0; next vector uses thresh 0 -> out_act=1.
//  6 Back-to-back vectors, out_ready=1: with BNN_PASSTHRU_EN no gap between vectors; without, exactly 1 bubble cycle.

Source files
------------

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared FSM state type, count-width and popcount helpers for the popcount neuron
package bnn_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;
  function automatic int cnt_width(input int beat_w, input int beats);
    return $clog2(beat_w * beats + 1);
  endfunction
  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/bnn_popcount8.sv
// bnn_popcount8: combinational popcount of one W-bit XNOR beat
module bnn_popcount8
  import bnn_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] cnt
);
  assign cnt = CW'(popcount(64'(bits)));
endmodule

// File: rtl/bnn_popcount_neuron.sv
// bnn_popcount_neuron: multi-beat popcount accumulate + threshold compare producing one activation per vector.
// Define BNN_PASSTHRU_EN to accept the next vector's first beat in the same cycle as the output handshake.
module bnn_popcount_neuron
  import bnn_pkg::*;
#(
  parameter int BEAT_W = 8,
  parameter int BEATS  = 4,
  parameter int CNT_W  = cnt_width(BEAT_W, BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_bits,
  input  logic              thresh_wr,
  input  logic [CNT_W-1:0]  thresh_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_act,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);
  localparam int BC_W = $clog2(BEATS + 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d, thresh_q, thresh_d, cnt_q, cnt_d, pc, sum;
  logic [BC_W-1:0]  bc_q, bc_d;
  logic             act_q, act_d, xfer, start, last;
  bnn_popcount8 #(.W(BEAT_W), .CW(CNT_W)) u_pc (.bits(in_bits), .cnt(pc));
`ifdef BNN_PASSTHRU_EN
  assign in_ready = (state_q != EMIT) | out_ready;
`else
  assign in_ready = state_q != EMIT;
`endif
  assign out_valid = state_q == EMIT;
  assign busy      = state_q != IDLE;
  assign out_count = cnt_q;
  assign out_act   = act_q;
  // A beat outside ACCUM always opens a fresh vector; the compare sees the pre-edge threshold
  always_comb begin
    xfer     = in_valid & in_ready;
    start    = state_q != ACCUM;
    sum      = start ? pc : acc_q + pc;
    last     = start ? (BEATS == 1) : (bc_q == BC_W'(BEATS - 1));
    acc_d    = xfer ? sum : acc_q;
    bc_d     = xfer ? (start ? BC_W'(1) : bc_q + BC_W'(1)) : bc_q;
    cnt_d    = (xfer && last) ? sum : cnt_q;
    act_d    = (xfer && last) ? (sum >= thresh_q) : act_q;
    thresh_d = thresh_wr ? thresh_in : thresh_q;
    state_d  = xfer ? (last ? EMIT : ACCUM) : ((state_q == EMIT && out_ready) ? IDLE : state_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      bc_q     <= '0;
      cnt_q    <= '0;
      act_q    <= 1'b0;
      thresh_q <= CNT_W'((BEAT_W * BEATS) / 2);
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      bc_q     <= bc_d;
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      thresh_q <= thresh_d;
    end
  end
endmodule

// File: tb/tb_bnn_popcount_neuron.sv
// tb_bnn_popcount_neuron: directed scoreboard bench for bnn_popcount_neuron (default 8x4 configuration)
module tb_bnn_popcount_neuron;
  logic       clk = 0, rst = 1, in_valid = 0, in_ready, thresh_wr = 0, out_valid, out_ready = 1, out_act, busy;
  logic [7:0] in_bits = 0;
  logic [5:0] thresh_in = 0, out_count;
  typedef struct {logic [5:0] c; logic a;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, waits = 0, thr = 16;
  bnn_popcount_neuron dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .thresh_wr(thresh_wr), .thresh_in(thresh_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_act(out_act), .out_count(out_count), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_output", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("out_count", 32'(out_count), 32'(e.c));
        check("out_act", 32'(out_act), 32'(e.a));
      end
    end
  end
  task automatic beat(input logic [7:0] b);
    int n;
    in_valid = 1;
    in_bits = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
      waits++;
    end
    check("beat_accept", 32'(in_ready), 1);
    @(negedge clk);
  endtask
  task automatic vec(input logic [31:0] v, input bit wr, input int nt);
    int s;
    exp_t e;
    s = 0;
    for (int i = 0; i < 4; i++) s += $countones(v[31-8*i -: 8]);
    e.c = 6'(s);
    e.a = s >= thr;
    q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && wr) begin
        thresh_wr = 1;
        thresh_in = 6'(nt);
      end
      beat(v[31-8*i -: 8]);
      thresh_wr = 0;
    end
    if (wr) thr = nt;
  endtask
  task automatic wr_thr(input int v);
    thresh_wr = 1;
    thresh_in = 6'(v);
    @(negedge clk);
    thresh_wr = 0;
    thr = v;
  endtask
  initial begin
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_count", 32'(out_count), 0);
    check("rst_out_act", 32'(out_act), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_busy", 32'(busy), 0);
    rst = 0;
    @(negedge clk);
    // mid-vector reset discards the partial sum
    beat(8'hFF);
    beat(8'hFF);
    in_valid = 0;
    rst = 1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    vec(32'hFFFFFFFF, 0, 0);
    in_valid = 0;
    @(negedge clk);
    // full-match vector, default threshold, latency check
    vec(32'hFFFFFFFF, 0, 0);
    in_valid = 0;
    check("latency_out_valid", 32'(out_valid), 1);
    check("emit_busy", 32'(busy), 1);
    @(negedge clk);
    check("post_hs_out_valid", 32'(out_valid), 0);
    vec(32'hFF0F0000, 0, 0);
    in_valid = 0;
    wr_thr(12);
    vec(32'hFF0F0000, 0, 0);
    in_valid = 0;
    wr_thr(13);
    vec(32'hFF0F0000, 0, 0);
    in_valid = 0;
    @(negedge clk);
    // backpressure with a pending beat must not capture it
    out_ready = 0;
    vec(32'hFF0F0000, 0, 0);
    in_bits = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_out_count", 32'(out_count), 12);
      check("bp_out_act", 32'(out_act), 0);
      check("bp_in_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    vec(32'h00000000, 0, 0);
    in_valid = 0;
    wr_thr(16);
    vec(32'hFF0F0000, 1, 0);
    in_valid = 0;
    vec(32'hFF0F0000, 0, 0);
    in_valid = 0;
    @(negedge clk);
    // back-to-back vectors: count cycles the first beat of the second vector stalls
    vec(32'h0F0F0F0F, 0, 0);
    waits = 0;
    vec(32'h01030307, 0, 0);
    in_valid = 0;
`ifdef BNN_PASSTHRU_EN
    check("b2b_bubbles", 32'(waits), 0);
`else
    check("b2b_bubbles", 32'(waits), 1);
`endif
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
